// File: rtl/fifo_push_arbiter.sv
// fifo_push_arbiter: two-producer round-robin push arbiter and pop gate for
// a shared scoreboard FIFO. Keeps its own occupancy count and provides a
// flush sequence (RUN -> DRAIN -> RUN) that empties the FIFO.
module fifo_push_arbiter #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8,
    parameter int CW    = 4
) (
    input  logic             CLK,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] data0,
    input  logic [WIDTH-1:0] data1,
    input  logic             pop_req,
    input  logic             flush,
    output logic             gnt0,
    output logic             gnt1,
    output logic             pop_gnt,
    output logic             fifo_push,
    output logic             fifo_pop,
    output logic [WIDTH-1:0] fifo_data_in,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full,
    output logic             busy,
    output logic             flush_done,
    output logic             pop_err
);

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } state_t;

    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

    state_t        state;
    state_t        state_next;
    logic          prio;
    logic [CW-1:0] count_next;

    // Occupancy flags come from the registered count, never from the FIFO.
    assign empty = (count == '0);
    assign full  = (count == DEPTH_CNT);
    assign busy  = (state == DRAIN);

    assign fifo_push = gnt0 | gnt1;
    assign fifo_pop  = pop_gnt;

    // State register: reset lands in RUN, which also aborts any drain.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (!rst) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Next state: enter DRAIN on flush, leave once the count reaches zero.
    always_comb begin
        // NOTE: default first so no path leaves state_next unassigned and
        // infers a latch.
        state_next = state;
        case (state)
            RUN:   if (flush) state_next = DRAIN;
            DRAIN: if (count_next == '0) state_next = RUN;
        endcase
    end

    // Output decode: push arbitration, pop gating and write-data mux,
    // all held at zero while reset is asserted.
    always_comb begin
        gnt0         = 1'b0;
        gnt1         = 1'b0;
        pop_gnt      = 1'b0;
        fifo_data_in = '0;
        if (rst) begin
            if (state == RUN && !full) begin
                if (req0 && req1) begin
                    gnt0 = !prio;
                    gnt1 = prio;
                end else begin
                    gnt0 = req0;
                    gnt1 = req1;
                end
            end
            if (state == DRAIN) begin
                pop_gnt = !empty;
            end else begin
                pop_gnt = pop_req && !empty;
            end
            fifo_data_in = gnt1 ? data1 : data0;
        end
    end

    // Count arithmetic: a push and a pop in the same cycle cancel out.
    always_comb begin
        count_next = count + {{(CW-1){1'b0}}, fifo_push}
                           - {{(CW-1){1'b0}}, fifo_pop};
    end

    // Datapath registers: occupancy, priority pointer and status flags.
    always_ff @(posedge CLK) begin
        if (!rst) begin
            count      <= '0;
            prio       <= 1'b0;
            flush_done <= 1'b0;
            pop_err    <= 1'b0;
        end else begin
            count      <= count_next;
            // The winner loses priority; with no grant the pointer holds.
            if (gnt0) begin
                prio <= 1'b1;
            end else if (gnt1) begin
                prio <= 1'b0;
            end
            flush_done <= (state == DRAIN) && (state_next == RUN);
            // Sticky: an illegal pop is flagged and never forwarded.
            if (state == RUN && pop_req && empty) begin
                pop_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Bench for fifo_push_arbiter: directed scenarios followed by random traffic,
// checked against a queue-based model of the arbiter plus a behavioural FIFO
// driven by the DUT's fifo_* pins.
module tb_fifo_push_arbiter;

    localparam int DEPTH = 8;
    localparam int WIDTH = 8;
    localparam int CW    = 4;

    logic             CLK = 1'b0;
    logic             rst = 1'b0;
    logic             req0 = 1'b0;
    logic             req1 = 1'b0;
    logic [WIDTH-1:0] data0 = '0;
    logic [WIDTH-1:0] data1 = '0;
    logic             pop_req = 1'b0;
    logic             flush = 1'b0;
    logic             gnt0, gnt1, pop_gnt, fifo_push, fifo_pop;
    logic [WIDTH-1:0] fifo_data_in;
    logic [CW-1:0]    count;
    logic             empty, full, busy, flush_done, pop_err;

    always #5 CLK = ~CLK;

    fifo_push_arbiter #(.DEPTH(DEPTH), .WIDTH(WIDTH), .CW(CW)) dut (
        .CLK(CLK), .rst(rst),
        .req0(req0), .req1(req1), .data0(data0), .data1(data1),
        .pop_req(pop_req), .flush(flush),
        .gnt0(gnt0), .gnt1(gnt1), .pop_gnt(pop_gnt),
        .fifo_push(fifo_push), .fifo_pop(fifo_pop), .fifo_data_in(fifo_data_in),
        .count(count), .empty(empty), .full(full), .busy(busy),
        .flush_done(flush_done), .pop_err(pop_err)
    );

    // Behavioural FIFO fed from the DUT pins, so popped data shows write order.
    logic [WIDTH-1:0] mem [DEPTH];
    logic [2:0]       wp, rp;
    logic [WIDTH-1:0] fifo_out;
    assign fifo_out = mem[rp];

    always @(posedge CLK) begin
        if (!rst) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (fifo_push) begin
                mem[wp] <= fifo_data_in;
                wp      <= wp + 3'd1;
            end
            if (fifo_pop) rp <= rp + 3'd1;
        end
    end

    int checks = 0;
    int errors = 0;

    // Reference model: contents as a queue, mode, priority and flags.
    logic [WIDTH-1:0] q[$];
    bit m_run   = 1'b1;
    bit m_prio  = 1'b0;
    bit m_err   = 1'b0;
    bit m_done  = 1'b0;
    bit m_valid = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, check combinational outputs, clock, advance
    // the model, check registered outputs.
    task automatic step(input logic rs, input logic r0, input logic r1,
                        input logic [WIDTH-1:0] d0, input logic [WIDTH-1:0] d1,
                        input logic pr, input logic fl);
        bit e_g0, e_g1, e_pg, m_full, m_empty;
        rst = rs; req0 = r0; req1 = r1; data0 = d0; data1 = d1;
        pop_req = pr; flush = fl;
        #1;
        m_full  = (q.size() == DEPTH);
        m_empty = (q.size() == 0);
        e_g0 = 1'b0; e_g1 = 1'b0; e_pg = 1'b0;
        if (rs) begin
            if (m_run && !m_full) begin
                if (r0 && r1) begin
                    e_g0 = !m_prio;
                    e_g1 = m_prio;
                end else begin
                    e_g0 = r0;
                    e_g1 = r1;
                end
            end
            e_pg = m_run ? (pr && !m_empty) : !m_empty;
        end
        check("gnt0", gnt0, e_g0);
        check("gnt1", gnt1, e_g1);
        check("pop_gnt", pop_gnt, e_pg);
        check("fifo_push", fifo_push, e_g0 | e_g1);
        check("fifo_pop", fifo_pop, e_pg);
        if (e_g0 || e_g1) check("fifo_data_in", fifo_data_in, e_g1 ? d1 : d0);
        if (e_pg) check("pop_data", fifo_out, q[0]);
        @(posedge CLK);
        if (!rs) begin
            q.delete();
            m_run = 1'b1; m_prio = 1'b0; m_err = 1'b0; m_done = 1'b0;
            m_valid = 1'b1;
        end else begin
            if (m_run && pr && m_empty) m_err = 1'b1;
            if (e_pg) void'(q.pop_front());
            if (e_g0) q.push_back(d0);
            if (e_g1) q.push_back(d1);
            if (e_g0) m_prio = 1'b1;
            else if (e_g1) m_prio = 1'b0;
            m_done = 1'b0;
            if (m_run) begin
                if (fl) m_run = 1'b0;
            end else if (q.size() == 0) begin
                m_run  = 1'b1;
                m_done = 1'b1;
            end
        end
        #1;
        if (m_valid) begin
            check("count", count, q.size());
            check("empty", empty, q.size() == 0);
            check("full", full, q.size() == DEPTH);
            check("busy", busy, !m_run);
            check("flush_done", flush_done, m_done);
            check("pop_err", pop_err, m_err);
        end
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic pop1();
        step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
    endtask

    task automatic push0();
        step(1'b1, 1'b1, 1'b0, 8'($urandom), 8'h00, 1'b0, 1'b0);
    endtask

    initial begin
        // Reset held with all requests active.
        repeat (2) step(1'b0, 1'b1, 1'b1, 8'h11, 8'h22, 1'b1, 1'b0);
        check("reset_count", count, 0);
        check("reset_empty", empty, 1);

        // Contention: alternating grants, then pops come out A0,B1,A0,B1.
        repeat (4) step(1'b1, 1'b1, 1'b1, 8'hA0, 8'hB1, 1'b0, 1'b0);
        check("contention_count", count, 4);
        repeat (4) pop1();
        check("contention_drained", empty, 1);

        // Full boundary: ninth request refused, then pop+push nets to 7.
        repeat (9) push0();
        check("full_flag", full, 1);
        step(1'b1, 1'b1, 1'b0, 8'h5C, 8'h00, 1'b1, 1'b0);
        check("full_pop_push_count", count, 7);

        // Simultaneous push and pop at count 3.
        repeat (4) pop1();
        step(1'b1, 1'b1, 1'b0, 8'h3D, 8'h00, 1'b1, 1'b0);
        check("simul_count", count, 3);

        // Flush at count 5 with req0 held afterwards.
        repeat (2) push0();
        step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        check("flush_busy", busy, 1);
        repeat (8) push0();
        check("flush_after_count", count, 3);

        // Flush of an already-empty FIFO: one DRAIN cycle then done.
        repeat (3) pop1();
        step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        idle();
        check("empty_flush_done", flush_done, 1);

        // Pop while empty sets the sticky error flag.
        pop1();
        check("pop_err_set", pop_err, 1);
        repeat (3) push0();
        idle();
        check("pop_err_sticky", pop_err, 1);

        // Reset in the middle of a drain aborts it without flush_done.
        step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        idle();
        step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        check("abort_busy", busy, 0);
        idle();
        check("abort_no_done", flush_done, 0);

        // Random traffic with occasional flushes and resets.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) != 0),
                 1'($urandom), 1'($urandom),
                 8'($urandom), 8'($urandom),
                 1'($urandom),
                 ($urandom_range(0, 15) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_push_arbiter.md
# fifo_push_arbiter

Shares the 8-entry, 8-bit scoreboard FIFO between two producers and one consumer. It round-robin arbitrates producer pushes and gates consumer pops. It keeps its own occupancy count, because the FIFO's `empty`/`full` outputs are not trustworthy. It also provides a flush sequence that drains the FIFO before a new data-integrity run. It sits between the producer/consumer ports and the FIFO's `push`/`pop`/`data_in` pins, beside the data-integrity scoreboard.

## Interface
- `DEPTH`, 8: FIFO entries; must be a power of two and match the FIFO instance.
- `WIDTH`, 8: data width.
- `CW`, 4: count width, equal to log2(`DEPTH`)+1.
- `CLK`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-low (0 resets on the next `CLK` edge).
- `req0`, `req1`  in  1 each  producer push requests.
- `data0`, `data1`  in  `WIDTH` each  producer data, valid while the matching `req` is high.
- `pop_req`  in  1  consumer pop request.
- `flush`  in  1  request to drain the FIFO; sampled only in RUN.
- `gnt0`, `gnt1`  out  1 each  push grant; the producer's data is written this cycle.
- `pop_gnt`  out  1  pop accepted this cycle.
- `fifo_push`, `fifo_pop`  out  1 each  drive the FIFO `push`/`pop` pins.
- `fifo_data_in`  out  `WIDTH`  drives the FIFO `data_in` pin.
- `count`  out  `CW`  registered occupancy, range 0..`DEPTH`.
- `empty`, `full`  out  1 each  `count`==0 and `count`==`DEPTH`.
- `busy`  out  1  high while in DRAIN.
- `flush_done`  out  1  one-cycle pulse on the DRAIN→RUN transition.
- `pop_err`  out  1  sticky flag: `pop_req` was seen while `empty`.

## Operation
- State machine: RUN (reset state) and DRAIN.
  - RUN→DRAIN when `flush`=1.
  - DRAIN→RUN on the edge where `count` becomes 0; `flush_done`=1 for that following cycle.
  - If `count`=0 when `flush` is sampled: go to DRAIN for one cycle, then return to RUN with `flush_done`.
- Push arbitration is combinational from `req0`/`req1`, the priority pointer `prio`, `count` and the state.
  - No grant in DRAIN or when `full`.
  - Only one requester active: it is granted.
  - Both active: grant requester `prio`.
  - At most one grant per cycle; `gnt0` and `gnt1` are mutually exclusive.
- Priority pointer `prio` (1 bit, reset 0):
  - On `gntN`=1, `prio` ← !N.
  - With no grant, `prio` holds.
  - A producer holding `req` while the other gets granted is therefore served at most one cycle later.
- Write side:
  - `fifo_push` = `gnt0` | `gnt1`.
  - `fifo_data_in` = `data1` if `gnt1`, else `data0`.
  - When `fifo_push`=0, `fifo_data_in` is don't-care and the bench must not check it.
- Pop side:
  - In RUN, `pop_gnt` = `pop_req` & !`empty`.
  - In DRAIN, `pop_gnt` = !`empty`, regardless of `pop_req`.
  - `fifo_pop` = `pop_gnt`.
- Count update: `count` += `fifo_push` − `fifo_pop`, in `CW` bits.
  - Push and pop in the same cycle leave `count` unchanged.
  - Push is blocked when `full`, even if a pop is granted the same cycle. `count` can never exceed `DEPTH` or go below 0.
- `pop_err`: set when `pop_req` & `empty` in RUN; cleared only by reset. The illegal pop is not forwarded.
- Reset values: `count`=0, `empty`=1, `full`=0, `prio`=0, state RUN, `busy`=0, `flush_done`=0, `pop_err`=0.
- During reset (`rst`=0) all outputs are forced to these values, including `gnt*`, `pop_gnt` and `fifo_*`=0, which resets the FIFO pointers coherently.
- Reset asserted mid-DRAIN aborts the drain with no `flush_done`.

## Timing
- Grants, `fifo_push`, `fifo_pop` and `fifo_data_in` are combinational, with zero-cycle latency from `req*`/`pop_req`.
- `count`, `empty`, `full`, `busy`, `flush_done` and `pop_err` are registered and reflect the previous edge's transfers.
- The FIFO output is combinational from its read pointer. Consumer data is valid in the cycle `pop_gnt`=1.
- Push to earliest pop of the same entry: 1 cycle, because `empty` deasserts the cycle after the first push.
- A flush with N entries yields `busy` for N cycles and `flush_done` in cycle N+1 after `flush`.

## Test plan
- Reset: hold `rst`=0 for 2 cycles while driving `req0`, `req1`, `pop_req`. Required: all grants 0, `count`=0, `empty`=1, `pop_err`=0.
- Contention: hold `req0`=`req1`=1 with `data0`=0xA0, `data1`=0xB1 for 4 cycles. Required: grants alternate 0,1,0,1; `count`=4; consumer then pops A0,B1,A0,B1.
- Full boundary: push 8 values via `req0`. Required: `full`=1 and `gnt0`=0 on the ninth request. Then assert `pop_req`+`req0` together: pop granted, push blocked, `count`=7.
- Simultaneous transfer: `count`=3, one push and one pop in the same cycle. Required: `count` stays 3 and FIFO order is preserved.
- Flush: `count`=5, pulse `flush` with `req0` held. Required: `busy` for 5 cycles, no grants, 5 pops, `flush_done` at cycle 6, `count`=0, then `gnt0` resumes.
- Error flag: `pop_req` while empty. Required: `pop_gnt`=0, `pop_err`=1 and it stays set until `rst`=0.
